// File: rtl/trap_irq_controller.sv
// trap_irq_controller
//   Trap/interrupt controller for the Mini-RISC-V core. Latches NUM_IRQ
//   edge-triggered interrupt lines plus ecall, picks one by fixed priority
//   (ecall, then lowest IRQ index), and sequences TAKE -> HANDLER -> RET with
//   one-cycle trigger_trap / trigger_trap_ret pulses toward Fetch. Owns the
//   mie/mip/mtvec/mepc/mcause CSRs behind a small read/write port.
//
//   Optional feature macro: TRAP_VECTORED_EN
//     defined   : mtvec[0] is MODE; MODE=1 vectors interrupts to base+4*(16+i),
//                 ecall always goes to the base.
//     undefined : mtvec[1:0] hardwired to 0, trap_vector = mtvec.
//
// Ports
//   clk, Rst          clock, asynchronous active-low reset
//   irq_in            interrupt lines (already in clk domain)
//   ecall, trap_ret   ecall / mret decoded in ID this cycle
//   mem_hold          pipeline stall; blocks trap entry and return
//   epc_in            PC captured into mepc when a trap is taken
//   csr_we/sel/wdata  CSR write port (0 mie,1 mip,2 mtvec,3 mepc,4 mcause)
//   csr_rdata         combinational read of csr_sel, reserved selects read 0
//   trigger_trap      one-cycle pulse: redirect PC to trap_vector
//   trigger_trap_ret  one-cycle pulse: redirect PC to mepc
//   trapping          high in TAKE and HANDLER
//   trap_vector, mepc handler target / saved return PC
//   nest_err          sticky: trap request seen while already trapping
module trap_irq_controller #(
    parameter int                NUM_IRQ     = 4,
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_MTVEC = XLEN'(32'h0000_0100)
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                ecall,
    input  logic                trap_ret,
    input  logic                mem_hold,
    input  logic [XLEN-1:0]     epc_in,
    input  logic                csr_we,
    input  logic [2:0]          csr_sel,
    input  logic [XLEN-1:0]     csr_wdata,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                trigger_trap,
    output logic                trigger_trap_ret,
    output logic                trapping,
    output logic [XLEN-1:0]     trap_vector,
    output logic [XLEN-1:0]     mepc,
    output logic                nest_err
);

    typedef enum logic [1:0] {IDLE, TAKE, HANDLER, RET} state_t;

    state_t               state, state_nxt;
    logic [NUM_IRQ-1:0]   irq_prev, irq_edge, mip, mie, pend, win_oh, mip_clr;
    logic [XLEN-1:0]      mtvec, mcause, cause_nxt;
    logic [3:0]           win_idx;
    logic                 irq_any, req, take;
    logic                 wr_mie, wr_mip, wr_mtvec, wr_mepc, wr_mcause;

    assign irq_edge = irq_in & ~irq_prev;
    assign pend     = mip & mie;

    // Lowest pending, enabled IRQ index wins.
    always_comb begin
        irq_any = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !irq_any) begin
                irq_any   = 1'b1;
                win_idx   = 4'(i);
                win_oh[i] = 1'b1;
            end
        end
    end

    assign req  = ecall | irq_any;
    assign take = (state == IDLE) && req && !mem_hold;

    // IRQ cause is {1, 16+i}; with i<16 the low five bits are simply {1,i}.
    assign cause_nxt = ecall ? XLEN'(11)
                             : {1'b1, {(XLEN-6){1'b0}}, 1'b1, win_idx};

    assign wr_mie    = csr_we && (csr_sel == 3'd0);
    assign wr_mip    = csr_we && (csr_sel == 3'd1);
    assign wr_mtvec  = csr_we && (csr_sel == 3'd2);
    assign wr_mepc   = csr_we && (csr_sel == 3'd3);
    assign wr_mcause = csr_we && (csr_sel == 3'd4);

    // Clear sources: the channel being taken and write-1-to-clear from CSR.
    assign mip_clr = ((take && !ecall) ? win_oh : '0)
                   | (wr_mip ? csr_wdata[NUM_IRQ-1:0] : '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && !mem_hold)      state_nxt = TAKE;
            TAKE:                               state_nxt = HANDLER;
            HANDLER: if (trap_ret && !mem_hold) state_nxt = RET;
            RET:                                state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        trigger_trap     = 1'b0;
        trigger_trap_ret = 1'b0;
        trapping         = 1'b0;
        case (state)
            TAKE:    begin trigger_trap = 1'b1; trapping = 1'b1; end
            HANDLER: trapping = 1'b1;
            RET:     trigger_trap_ret = 1'b1;
            default: ;
        endcase
    end

    // ---------------- pending / enable ----------------
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            irq_prev <= '0;
            mip      <= '0;
            mie      <= '0;
        end else begin
            irq_prev <= irq_in;
            mip      <= (mip & ~mip_clr) | irq_edge;   // a new edge beats a clear
            if (wr_mie) mie <= csr_wdata[NUM_IRQ-1:0];
        end
    end

    // ---------------- mtvec / mepc / mcause ----------------
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
`ifdef TRAP_VECTORED_EN
            mtvec  <= {RESET_MTVEC[XLEN-1:2], 1'b0, RESET_MTVEC[0]};
`else
            mtvec  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
`endif
            mepc   <= '0;
            mcause <= '0;
        end else begin
            if (wr_mtvec) begin
`ifdef TRAP_VECTORED_EN
                mtvec <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
`else
                mtvec <= {csr_wdata[XLEN-1:2], 2'b00};
`endif
            end
            // Hardware capture on trap entry takes precedence over software.
            if (take) begin
                mepc   <= epc_in;
                mcause <= cause_nxt;
            end else begin
                if (wr_mepc)   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                if (wr_mcause) mcause <= csr_wdata;
            end
        end
    end

    // ---------------- nesting error ----------------
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)
            nest_err <= 1'b0;
        else if (trapping && (ecall || |(irq_edge & mie)))
            nest_err <= 1'b1;
    end

    // ---------------- trap target ----------------
    // Derived from the latched mcause so it is stable from TAKE onward.
    always_comb begin
`ifdef TRAP_VECTORED_EN
        trap_vector = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[0] && mcause[XLEN-1])
            trap_vector = {mtvec[XLEN-1:2], 2'b00} + XLEN'({mcause[4:0], 2'b00});
`else
        trap_vector = mtvec;
`endif
    end

    // ---------------- CSR read ----------------
    always_comb begin
        csr_rdata = '0;
        case (csr_sel)
            3'd0:    csr_rdata = XLEN'(mie);
            3'd1:    csr_rdata = XLEN'(mip);
            3'd2:    csr_rdata = mtvec;
            3'd3:    csr_rdata = mepc;
            3'd4:    csr_rdata = mcause;
            default: csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_irq_controller.sv
// Bench for trap_irq_controller: CSR read table for the reset state, hand
// sequences for the trap flows, and a queue of expected trap entries that a
// negedge monitor pops whenever trigger_trap fires.
module tb_trap_irq_controller;

    localparam int N = 4;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            Rst = 1'b0;
    logic [N-1:0]    irq_in = '0;
    logic            ecall = 1'b0, trap_ret = 1'b0, mem_hold = 1'b0;
    logic [XLEN-1:0] epc_in = '0;
    logic            csr_we = 1'b0;
    logic [2:0]      csr_sel = '0;
    logic [XLEN-1:0] csr_wdata = '0;
    logic [XLEN-1:0] csr_rdata, trap_vector, mepc;
    logic            trigger_trap, trigger_trap_ret, trapping, nest_err;

    trap_irq_controller #(.NUM_IRQ(N), .XLEN(XLEN), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .Rst(Rst), .irq_in(irq_in), .ecall(ecall), .trap_ret(trap_ret),
        .mem_hold(mem_hold), .epc_in(epc_in), .csr_we(csr_we), .csr_sel(csr_sel),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trigger_trap(trigger_trap),
        .trigger_trap_ret(trigger_trap_ret), .trapping(trapping),
        .trap_vector(trap_vector), .mepc(mepc), .nest_err(nest_err)
    );

    always #10 clk = ~clk;

    typedef struct { logic [31:0] mcause; logic [31:0] mepc; logic [31:0] tv; } exp_t;
    typedef struct { logic [2:0] sel; logic [31:0] val; string nm; } csr_vec_t;

    exp_t     sb[$];
    exp_t     mon_e;
    csr_vec_t rvec[8];
    int       n_vec = 0;
    int       n_err = 0;
    logic [31:0] rd;
    logic [31:0] tv6;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_wr(input logic [2:0] s, input logic [31:0] d);
        csr_we = 1'b1; csr_sel = s; csr_wdata = d;
        tick();
        csr_we = 1'b0; csr_wdata = '0;
    endtask

    task automatic csr_rd(input logic [2:0] s, output logic [31:0] d);
        csr_sel = s; #1; d = csr_rdata;
    endtask

    task automatic check_reset(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            csr_rd(rvec[i].sel, v);
            chk({tag, "_", rvec[i].nm}, v, rvec[i].val);
        end
        chk({tag, "_trigger_trap"}, 32'(trigger_trap), 0);
        chk({tag, "_trigger_ret"},  32'(trigger_trap_ret), 0);
        chk({tag, "_trapping"},     32'(trapping), 0);
        chk({tag, "_nest_err"},     32'(nest_err), 0);
        chk({tag, "_trap_vector"},  trap_vector, 32'h100);
        chk({tag, "_mepc_out"},     mepc, 0);
    endtask

    // HANDLER -> RET -> IDLE
    task automatic do_mret(input string tag);
        trap_ret = 1'b1;
        tick();
        trap_ret = 1'b0;
        chk({tag, "_ret_pulse"}, 32'(trigger_trap_ret), 1);
        chk({tag, "_ret_trapping"}, 32'(trapping), 0);
        tick();
        chk({tag, "_ret_done"}, 32'(trigger_trap_ret), 0);
    endtask

    // Scoreboard: every trigger_trap must match the oldest queued expectation.
    always @(negedge clk) begin
        if (Rst && trigger_trap) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_trap: got trigger_trap=1, want no trap");
            end else begin
                mon_e = sb.pop_front();
                chk("sb_mepc", mepc, mon_e.mepc);
                chk("sb_trap_vector", trap_vector, mon_e.tv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rvec[0] = '{3'd0, 32'h0,   "mie"};
        rvec[1] = '{3'd1, 32'h0,   "mip"};
        rvec[2] = '{3'd2, 32'h100, "mtvec"};
        rvec[3] = '{3'd3, 32'h0,   "mepc"};
        rvec[4] = '{3'd4, 32'h0,   "mcause"};
        rvec[5] = '{3'd5, 32'h0,   "rsv5"};
        rvec[6] = '{3'd6, 32'h0,   "rsv6"};
        rvec[7] = '{3'd7, 32'h0,   "rsv7"};
`ifdef TRAP_VECTORED_EN
        tv6 = 32'h1044;
`else
        tv6 = 32'h1000;
`endif

        // 1. reset
        repeat (3) @(posedge clk);
        #1 Rst = 1'b1;
        check_reset("rst");

        // 2. single IRQ, two-edge latency
        csr_wr(3'd0, 32'h4);
        epc_in = 32'h200; irq_in = 4'b0100;
        sb.push_back('{32'h8000_0012, 32'h200, 32'h100});
        tick();
        chk("t2_no_trap_yet", 32'(trigger_trap), 0);
        tick();
        chk("t2_trigger", 32'(trigger_trap), 1);
        chk("t2_trapping", 32'(trapping), 1);
        csr_rd(3'd4, rd); chk("t2_mcause", rd, 32'h8000_0012);
        csr_rd(3'd1, rd); chk("t2_mip", rd, 32'h0);
        chk("t2_mepc", mepc, 32'h200);
        irq_in = '0;
        tick();
        chk("t2_handler_no_pulse", 32'(trigger_trap), 0);
        chk("t2_handler_trapping", 32'(trapping), 1);
        do_mret("t2");

        // 3. two IRQs at once: lowest index first, the other after mret
        csr_wr(3'd0, 32'hF);
        epc_in = 32'h300; irq_in = 4'b1010;
        sb.push_back('{32'h8000_0011, 32'h300, 32'h100});
        tick(); tick();
        chk("t3_trigger1", 32'(trigger_trap), 1);
        csr_rd(3'd4, rd); chk("t3_mcause1", rd, 32'h8000_0011);
        csr_rd(3'd1, rd); chk("t3_mip_left", rd, 32'h8);
        irq_in = '0; epc_in = 32'h340;
        sb.push_back('{32'h8000_0013, 32'h340, 32'h100});
        tick();
        trap_ret = 1'b1;
        tick();
        trap_ret = 1'b0;
        chk("t3_ret_pulse", 32'(trigger_trap_ret), 1);
        chk("t3_ret_no_trap", 32'(trigger_trap), 0);
        tick();
        chk("t3_idle_no_trap", 32'(trigger_trap), 0);
        tick();
        chk("t3_trigger2", 32'(trigger_trap), 1);
        csr_rd(3'd4, rd); chk("t3_mcause2", rd, 32'h8000_0013);
        csr_rd(3'd1, rd); chk("t3_mip_empty", rd, 32'h0);
        tick();
        do_mret("t3b");

        // 4. ecall blocked by mem_hold, then taken; concurrent mcause write loses
        csr_wr(3'd0, 32'h0);
        mem_hold = 1'b1; ecall = 1'b1; epc_in = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_no_trap", 32'(trigger_trap), 0);
            chk("t4_hold_no_trapping", 32'(trapping), 0);
        end
        sb.push_back('{32'd11, 32'h400, 32'h100});
        mem_hold = 1'b0;
        csr_we = 1'b1; csr_sel = 3'd4; csr_wdata = 32'hDEAD;
        tick();
        csr_we = 1'b0; csr_wdata = '0; ecall = 1'b0;
        chk("t4_trigger", 32'(trigger_trap), 1);
        chk("t4_trap_vector", trap_vector, 32'h100);
        csr_rd(3'd4, rd); chk("t4_mcause", rd, 32'd11);
        tick();

        // 5. IRQ edge inside HANDLER: nest_err, pends, no second trap
        chk("t5_nest_clear", 32'(nest_err), 0);
        csr_wr(3'd0, 32'h1);
        irq_in = 4'b0001;
        tick();
        chk("t5_nest_err", 32'(nest_err), 1);
        csr_rd(3'd1, rd); chk("t5_mip_pend", rd, 32'h1);
        irq_in = '0;
        tick(); tick();
        chk("t5_no_second_trap", 32'(trigger_trap), 0);
        chk("t5_still_trapping", 32'(trapping), 1);
        epc_in = 32'h500;
        sb.push_back('{32'h8000_0010, 32'h500, 32'h100});
        trap_ret = 1'b1;
        tick();
        trap_ret = 1'b0;
        tick(); tick();
        chk("t5_pend_taken", 32'(trigger_trap), 1);
        tick();
        do_mret("t5");
        chk("t5_nest_sticky", 32'(nest_err), 1);

        // CSR corner cases
        csr_wr(3'd0, 32'hFFFF_FFFF);
        csr_rd(3'd0, rd); chk("csr_mie_width", rd, 32'hF);
        csr_wr(3'd0, 32'h0);
        irq_in = 4'b0010;
        tick();
        irq_in = '0;
        csr_rd(3'd1, rd); chk("csr_mip_masked_set", rd, 32'h2);
        csr_wr(3'd1, 32'h2);
        csr_rd(3'd1, rd); chk("csr_mip_w1c", rd, 32'h0);
        csr_we = 1'b1; csr_sel = 3'd1; csr_wdata = 32'h8; irq_in = 4'b1000;
        tick();
        csr_we = 1'b0; csr_wdata = '0; irq_in = '0;
        csr_rd(3'd1, rd); chk("csr_mip_set_wins", rd, 32'h8);
        csr_wr(3'd1, 32'h8);
        csr_wr(3'd3, 32'h1237);
        csr_rd(3'd3, rd); chk("csr_mepc_align", rd, 32'h1234);
        chk("csr_mepc_out", mepc, 32'h1234);
        csr_wr(3'd4, 32'h55);
        csr_rd(3'd4, rd); chk("csr_mcause_wr", rd, 32'h55);
        csr_wr(3'd5, 32'hFFFF_FFFF);
        csr_rd(3'd5, rd); chk("csr_reserved", rd, 32'h0);

        // 6. mtvec mode / vectoring, then reset during HANDLER
        csr_wr(3'd2, 32'h1001);
        csr_rd(3'd2, rd);
`ifdef TRAP_VECTORED_EN
        chk("t6_mtvec", rd, 32'h1001);
`else
        chk("t6_mtvec", rd, 32'h1000);
`endif
        csr_wr(3'd0, 32'h2);
        epc_in = 32'h600; irq_in = 4'b0010;
        sb.push_back('{32'h8000_0011, 32'h600, tv6});
        tick(); tick();
        irq_in = '0;
        chk("t6_trigger", 32'(trigger_trap), 1);
        chk("t6_trap_vector", trap_vector, tv6);
        tick();
        chk("t6_in_handler", 32'(trapping), 1);
        Rst = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        chk("t6_rst_no_pulse", 32'(trigger_trap | trigger_trap_ret), 0);
        Rst = 1'b1;
        tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
